// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register in-flight write counters for RAW and
// saturation hazard detection, a single-branch control-hazard flag and a
// sticky error flag for writeback underflow or out-of-range indices.
module reg_scoreboard #(
  parameter int NUM_REGS     = 16,
  parameter int IDX_W        = 4,
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2
) (
  input  logic                I_CLOCK,
  input  logic                I_RESET,
  input  logic                I_LOCK,
  input  logic                I_IssueValid,
  input  logic                I_Src1Used,
  input  logic                I_Src2Used,
  input  logic [IDX_W-1:0]    I_Src1Idx,
  input  logic [IDX_W-1:0]    I_Src2Idx,
  input  logic                I_DestWrite,
  input  logic [IDX_W-1:0]    I_DestIdx,
  input  logic                I_IsBranch,
  input  logic                I_WBValid,
  input  logic [IDX_W-1:0]    I_WBIdx,
  input  logic                I_BranchResolved,
  output logic                O_DepStallSignal,
  output logic                O_BranchStallSignal,
  output logic                O_IssueAccept,
  output logic [NUM_REGS-1:0] O_BusyVector,
  output logic                O_Error
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic                bp_q, bp_d;
  logic                err_q, err_d;
  logic [NUM_REGS-1:0] busy;

  logic raw, sat, wb_hit_nz;
  logic s1_ok, s2_ok, dest_ok;
  logic dep, accept;

  // Busy bits come straight from the counters, so they show post-edge state.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) busy[r] = (cnt_q[r] != '0);
  end

  // Hazard lookup by index scan: an out-of-range index matches no register,
  // so it never stalls and never decrements.
  always_comb begin
    raw       = 1'b0;
    sat       = 1'b0;
    wb_hit_nz = 1'b0;
    s1_ok     = 1'b0;
    s2_ok     = 1'b0;
    dest_ok   = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (I_Src1Idx == IDX_W'(r)) begin
        s1_ok = 1'b1;
        if (I_Src1Used && busy[r]) raw = 1'b1;
      end
      if (I_Src2Idx == IDX_W'(r)) begin
        s2_ok = 1'b1;
        if (I_Src2Used && busy[r]) raw = 1'b1;
      end
      if (I_DestIdx == IDX_W'(r)) begin
        dest_ok = 1'b1;
        if (I_DestWrite && cnt_q[r] == CNT_MAX) sat = 1'b1;
      end
      if (I_WBIdx == IDX_W'(r) && busy[r]) wb_hit_nz = 1'b1;
    end
  end

  // Issue/stall decisions; a frozen pipeline stalls both fetch paths.
  always_comb begin
    dep    = (I_IssueValid & (raw | sat)) | ~I_LOCK;
    accept = I_IssueValid & I_LOCK & ~dep & ~bp_q;
  end

  assign O_DepStallSignal    = dep;
  assign O_IssueAccept       = accept;
  assign O_BranchStallSignal = bp_q | ~I_LOCK;
  assign O_BusyVector        = busy;
  assign O_Error             = err_q;

  // Next-state: inc/dec per counter (cancel when both hit), branch set wins
  // over resolve, error sticks once raised.
  always_comb begin
    logic inc, dec;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc = accept & I_DestWrite & (I_DestIdx == IDX_W'(r));
      dec = I_LOCK & I_WBValid & (I_WBIdx == IDX_W'(r)) & busy[r];
      cnt_d[r] = cnt_q[r];
      if (inc && !dec)      cnt_d[r] = cnt_q[r] + CNT_W'(1);
      else if (dec && !inc) cnt_d[r] = cnt_q[r] - CNT_W'(1);
    end

    bp_d = bp_q;
    if (I_LOCK) begin
      if (accept && I_IsBranch) bp_d = 1'b1;
      else if (I_BranchResolved) bp_d = 1'b0;
    end

    err_d = err_q;
    if (I_LOCK) begin
      if (I_WBValid && !wb_hit_nz) err_d = 1'b1;
      if (accept && ((I_DestWrite && !dest_ok) ||
                     (I_Src1Used && !s1_ok) ||
                     (I_Src2Used && !s2_ok))) err_d = 1'b1;
    end
  end

  // State registers; reset overrides every other input.
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      bp_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      bp_q  <= bp_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: table of per-cycle inputs with hand-computed expected
// outputs (values before the edge that commits the row), plus a short
// hand-written reset / lock sequence. NUM_REGS=12 so out-of-range indices
// are reachable.
module tb_reg_scoreboard;
  localparam int NR = 12;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst, lock, iv, s1u, s2u, dw, br, wbv, bres;
  logic [IW-1:0] s1i, s2i, di, wbi;
  logic          dep, bst, acc, err;
  logic [NR-1:0] busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_scoreboard #(.NUM_REGS(NR), .IDX_W(IW), .MAX_INFLIGHT(3), .CNT_W(2)) dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock), .I_IssueValid(iv),
    .I_Src1Used(s1u), .I_Src2Used(s2u), .I_Src1Idx(s1i), .I_Src2Idx(s2i),
    .I_DestWrite(dw), .I_DestIdx(di), .I_IsBranch(br),
    .I_WBValid(wbv), .I_WBIdx(wbi), .I_BranchResolved(bres),
    .O_DepStallSignal(dep), .O_BranchStallSignal(bst), .O_IssueAccept(acc),
    .O_BusyVector(busy), .O_Error(err)
  );

  typedef struct {
    int rst, lock, iv, s1u, s1i, s2u, s2i, dw, di, br, wbv, wbi, bres;
    int e_dep, e_acc, e_bst, e_busy, e_err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int row, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h want=%0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst  = v.rst[0];  lock = v.lock[0]; iv  = v.iv[0];
    s1u  = v.s1u[0];  s1i  = IW'(v.s1i); s2u = v.s2u[0]; s2i = IW'(v.s2i);
    dw   = v.dw[0];   di   = IW'(v.di);  br  = v.br[0];
    wbv  = v.wbv[0];  wbi  = IW'(v.wbi); bres = v.bres[0];
  endtask

  initial begin
    // rst lock iv s1u s1i s2u s2i dw di br wbv wbi bres | dep acc bst busy err
    vq.push_back('{0,1,1,0,0,0,0,1,3,0,0,0,0,   0,1,0,'h000,0}); // 0 issue d3
    vq.push_back('{0,1,1,0,0,1,3,0,0,0,0,0,0,   1,0,0,'h008,0}); // 1 src2=r3 RAW
    vq.push_back('{0,1,1,1,3,0,0,0,0,0,1,3,0,   1,0,0,'h008,0}); // 2 wb r3, no bypass
    vq.push_back('{0,1,1,1,3,0,0,0,0,0,0,0,0,   0,1,0,'h000,0}); // 3 stall gone
    vq.push_back('{0,1,1,0,0,0,0,1,5,0,0,0,0,   0,1,0,'h000,0}); // 4 d5 #1
    vq.push_back('{0,1,1,0,0,0,0,1,5,0,0,0,0,   0,1,0,'h020,0}); // 5 d5 #2
    vq.push_back('{0,1,1,0,0,0,0,1,5,0,0,0,0,   0,1,0,'h020,0}); // 6 d5 #3
    vq.push_back('{0,1,1,0,0,0,0,1,5,0,0,0,0,   1,0,0,'h020,0}); // 7 saturated
    vq.push_back('{0,1,1,0,0,0,0,1,5,0,1,5,0,   1,0,0,'h020,0}); // 8 still sat, wb r5
    vq.push_back('{0,1,1,0,0,0,0,1,5,0,0,0,0,   0,1,0,'h020,0}); // 9 fourth issues
    vq.push_back('{0,1,1,0,0,0,0,1,5,0,0,0,0,   1,0,0,'h020,0}); // 10 count back at 3
    vq.push_back('{0,1,1,0,0,0,0,1,7,0,0,0,0,   0,1,0,'h020,0}); // 11 d7 -> 1
    vq.push_back('{0,1,1,0,0,0,0,1,7,0,1,7,0,   0,1,0,'h0A0,0}); // 12 inc+dec r7
    vq.push_back('{0,1,0,0,0,0,0,0,0,0,1,7,0,   0,0,0,'h0A0,0}); // 13 wb r7 -> 0
    vq.push_back('{0,1,0,0,0,0,0,0,0,0,0,0,0,   0,0,0,'h020,0}); // 14 idle
    vq.push_back('{0,1,1,0,0,0,0,0,0,1,0,0,0,   0,1,0,'h020,0}); // 15 branch
    vq.push_back('{0,1,1,0,0,0,0,1,1,0,0,0,0,   0,0,1,'h020,0}); // 16 blocked
    vq.push_back('{0,1,0,0,0,0,0,0,0,0,0,0,1,   0,0,1,'h020,0}); // 17 resolve
    vq.push_back('{0,1,1,0,0,0,0,1,1,0,0,0,0,   0,1,0,'h020,0}); // 18 d1 issues
    vq.push_back('{0,1,1,0,0,0,0,0,0,1,0,0,1,   0,1,0,'h022,0}); // 19 branch+resolve
    vq.push_back('{0,1,0,0,0,0,0,0,0,0,0,0,0,   0,0,1,'h022,0}); // 20 set won
    vq.push_back('{0,0,1,0,0,0,0,1,2,0,0,0,1,   1,0,1,'h022,0}); // 21 lock=0 frozen
    vq.push_back('{0,1,0,0,0,0,0,0,0,0,0,0,1,   0,0,1,'h022,0}); // 22 resolve
    vq.push_back('{0,1,0,0,0,0,0,0,0,0,0,0,1,   0,0,0,'h022,0}); // 23 stray resolve ok
    vq.push_back('{0,1,0,0,0,0,0,0,0,0,1,2,0,   0,0,0,'h022,0}); // 24 wb r2 underflow
    vq.push_back('{0,1,0,0,0,0,0,0,0,0,0,0,0,   0,0,0,'h022,1}); // 25 error set
    vq.push_back('{0,1,0,0,0,0,0,0,0,0,0,0,0,   0,0,0,'h022,1}); // 26 sticky
    vq.push_back('{0,1,1,0,0,0,0,1,1,0,0,0,0,   0,1,0,'h022,1}); // 27 r1 -> 2
    vq.push_back('{0,1,1,0,0,0,0,0,0,1,0,0,0,   0,1,0,'h022,1}); // 28 branch pending
    vq.push_back('{1,1,1,0,0,0,0,1,4,0,1,5,0,   0,0,1,'h022,1}); // 29 reset overrides
    vq.push_back('{0,1,0,0,0,0,0,0,0,0,0,0,0,   0,0,0,'h000,0}); // 30 all clear
    vq.push_back('{0,1,0,0,0,0,0,0,0,0,1,5,0,   0,0,0,'h000,0}); // 31 wb r5 post-reset
    vq.push_back('{0,1,0,0,0,0,0,0,0,0,0,0,0,   0,0,0,'h000,1}); // 32 error
    vq.push_back('{1,1,0,0,0,0,0,0,0,0,0,0,0,   0,0,0,'h000,1}); // 33 reset
    vq.push_back('{0,1,0,0,0,0,0,0,0,0,0,0,0,   0,0,0,'h000,0}); // 34 cleared
    vq.push_back('{0,1,1,0,0,0,0,1,12,0,0,0,0,  0,1,0,'h000,0}); // 35 dest out of range
    vq.push_back('{0,1,0,0,0,0,0,0,0,0,0,0,0,   0,0,0,'h000,1}); // 36 ignored, error
    vq.push_back('{1,1,0,0,0,0,0,0,0,0,0,0,0,   0,0,0,'h000,1}); // 37 reset
    vq.push_back('{0,1,0,0,0,0,0,0,0,0,1,13,0,  0,0,0,'h000,0}); // 38 wb out of range
    vq.push_back('{0,1,0,0,0,0,0,0,0,0,0,0,0,   0,0,0,'h000,1}); // 39 error, no busy

    // Reset with all other inputs quiet, then check post-reset state.
    drive('{1,1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", -1, int'(busy), 0);
    chk("rst_err",  -1, int'(err),  0);
    chk("rst_bst",  -1, int'(bst),  0);
    chk("rst_dep",  -1, int'(dep),  0);
    chk("rst_acc",  -1, int'(acc),  0);

    // Lock low (between edges): both stalls assert, nothing issues.
    lock = 1'b0; iv = 1'b1;
    #1;
    chk("nolock_dep", -1, int'(dep), 1);
    chk("nolock_bst", -1, int'(bst), 1);
    chk("nolock_acc", -1, int'(acc), 0);
    lock = 1'b1; iv = 1'b0;

    foreach (vq[i]) begin
      @(posedge clk);
      #1 drive(vq[i]);
      @(negedge clk);
      chk("dep",  i, int'(dep),  vq[i].e_dep);
      chk("acc",  i, int'(acc),  vq[i].e_acc);
      chk("bst",  i, int'(bst),  vq[i].e_bst);
      chk("busy", i, int'(busy), vq[i].e_busy);
      chk("err",  i, int'(err),  vq[i].e_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 16, number of architectural registers tracked.
REQ-002 Parameter IDX_W, default 4, register index width; NUM_REGS SHALL be <= 2**IDX_W.
REQ-003 Parameter MAX_INFLIGHT, default 3, maximum outstanding writes per register (decode-to-writeback depth).
REQ-004 Parameter CNT_W, default 2, per-register counter width; MAX_INFLIGHT SHALL be <= 2**CNT_W-1.
REQ-005 I_CLOCK  in  1  sole clock; all state updates on rising edge.
REQ-006 I_RESET  in  1  synchronous, active-high reset.
REQ-007 I_LOCK  in  1  pipeline running; when 0, no state updates and both stall outputs SHALL be 1.
REQ-008 I_IssueValid  in  1  decode presents an instruction this cycle.
REQ-009 I_Src1Used, I_Src2Used  in  1 each  source operand valid flags.
REQ-010 I_Src1Idx, I_Src2Idx  in  IDX_W each  source register indices.
REQ-011 I_DestWrite  in  1  instruction writes I_DestIdx.
REQ-012 I_DestIdx  in  IDX_W  destination register index.
REQ-013 I_IsBranch  in  1  instruction is a control transfer.
REQ-014 I_WBValid  in  1  writeback retiring a register write this cycle.
REQ-015 I_WBIdx  in  IDX_W  writeback destination index.
REQ-016 I_BranchResolved  in  1  one-cycle pulse from memory stage: branch target known.
REQ-017 O_DepStallSignal  out  1  combinational data-hazard stall to fetch/decode.
REQ-018 O_BranchStallSignal  out  1  registered control-hazard stall to fetch.
REQ-019 O_IssueAccept  out  1  combinational: instruction issues this cycle.
REQ-020 O_BusyVector  out  NUM_REGS  bit r = (count[r] != 0), registered.
REQ-021 O_Error  out  1  sticky underflow/out-of-range flag.

Function
REQ-022 State: count[r] (CNT_W bits) per register; branch_pending flag; error flag.
REQ-023 RAW hazard: any used source r with count[r] != 0.
REQ-024 Saturation hazard: I_DestWrite=1 and count[I_DestIdx] == MAX_INFLIGHT.
REQ-025 O_DepStallSignal = I_IssueValid & (RAW | saturation hazard), or ~I_LOCK.
REQ-026 O_IssueAccept = I_IssueValid & I_LOCK & ~O_DepStallSignal & ~branch_pending.
REQ-027 O_BranchStallSignal = branch_pending | ~I_LOCK.
REQ-028 Accepted issue with I_DestWrite=1 SHALL increment count[I_DestIdx] at the next edge.
REQ-029 I_WBValid=1 with count[I_WBIdx] != 0 SHALL decrement count[I_WBIdx] at the next edge.
REQ-030 Same-cycle increment and decrement on the same index SHALL leave the count unchanged; different indices update independently.
REQ-031 I_WBValid with count[I_WBIdx] == 0 SHALL leave counts unchanged and set O_Error.
REQ-032 Any index >= NUM_REGS on an accepted issue or valid writeback SHALL be ignored and set O_Error.
REQ-033 Accepted issue with I_IsBranch=1 SHALL set branch_pending at the next edge.
REQ-034 I_BranchResolved=1 SHALL clear branch_pending at the next edge; if a branch is accepted in the same cycle, set wins.
REQ-035 I_BranchResolved with branch_pending=0 SHALL be ignored (no error).
REQ-036 Writeback in cycle N SHALL not clear a RAW hazard until cycle N+1 (no same-cycle bypass).
REQ-037 O_BusyVector SHALL reflect counts after the edge (one-cycle latency from issue/writeback).

Reset
REQ-038 I_RESET=1 at an edge SHALL clear all counts, branch_pending and error, overriding all other inputs that cycle.
REQ-039 After reset: O_BusyVector=0, O_Error=0, O_BranchStallSignal=~I_LOCK, O_DepStallSignal=~I_LOCK.
REQ-040 Reset mid-operation discards all in-flight tracking; later writebacks to cleared registers SHALL set O_Error.

Verification
REQ-041 Issue dest r3, next cycle issue src1=r3 -> O_DepStallSignal=1, O_IssueAccept=0; after I_WBValid r3, stall drops the following cycle.
REQ-042 Issue dest r5 three times (MAX_INFLIGHT=3), fourth issue dest r5 -> stalled; one writeback r5 -> fourth issues, count[r5]=3.
REQ-043 Same cycle: accepted issue dest r7 and I_WBValid r7 with count[r7]=1 -> count[r7] stays 1, O_BusyVector[7]=1.
REQ-044 Accepted branch -> O_BranchStallSignal=1 next cycle, further issues blocked; I_BranchResolved pulse -> 0 the cycle after.
REQ-045 I_WBValid r2 with count[r2]=0 -> O_Error=1 and remains 1 until I_RESET.
REQ-046 Counts r1=2, branch_pending=1, assert I_RESET one cycle -> O_BusyVector=0, O_BranchStallSignal=0, O_Error=0.
